// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through read, exact occupancy,
// programmable almost flags, sticky overflow/underflow and synchronous flush.
module sync_fifo #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 4,
  parameter bit FWFT       = 1'b0,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_clr_err,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_full,
  output logic                  o_almost_full,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_rd_empty,
  output logic                  o_almost_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_MAX = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_T    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   AE_T    = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, head_idx;
  logic [ADDR_WIDTH:0]   count_q, count_d, remain;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  empty, full, wr_acc, rd_acc;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_MAX);

  always_comb begin
    rd_acc   = i_rd_en && !empty && !i_flush;
    wr_acc   = i_wr_en && (!full || rd_acc) && !i_flush;
    remain   = rd_acc ? count_q - CNT_ONE : count_q;
    head_idx = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = head_idx;
    count_d  = count_q;
    if (wr_acc && !rd_acc)      count_d = count_q + CNT_ONE;
    else if (!wr_acc && rd_acc) count_d = count_q - CNT_ONE;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    rd_valid_d = rd_acc;
    rd_data_d  = rd_data_q;
    if (FWFT) begin
      // Output stage mirrors the post-edge head; when the only remaining word is
      // the one being written, take it straight from the write port.
      if (!i_flush && count_d != '0)
        rd_data_d = (remain == '0) ? i_wr_data : mem_q[head_idx];
    end else if (rd_acc) begin
      rd_data_d = mem_q[rd_ptr_q];
    end
    // Set wins over clear when both land in the same cycle.
    ovf_d = (i_wr_en && full && !rd_acc && !i_flush) || (ovf_q && !i_clr_err);
    unf_d = (i_rd_en && empty && !i_flush) || (unf_q && !i_clr_err);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= i_wr_data;
  end

  assign o_count        = count_q;
  assign o_full         = full;
  assign o_rd_empty     = empty;
  assign o_almost_full  = (count_q >= AF_T);
  assign o_almost_empty = (count_q <= AE_T);
  assign o_rd_data      = rd_data_q;
  assign o_rd_valid     = FWFT ? !empty : rd_valid_q;
  assign o_overflow     = ovf_q;
  assign o_underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: standard and FWFT instances share stimulus and are checked
// against a queue-based reference model, vector table and directed corner sequences.
module tb_sync_fifo;
  localparam int DW = 12, AW = 4, DEPTH = 16, AF = DEPTH - 2, AE = 2;

  logic clk = 1'b0;
  logic rst, flush, clr, wr, rd;
  logic [DW-1:0] wdata;
  logic s_full, s_af, s_valid, s_empty, s_ae, s_ovf, s_unf;
  logic f_full, f_af, f_valid, f_empty, f_ae, f_ovf, f_unf;
  logic [DW-1:0] s_data, f_data;
  logic [AW:0] s_count, f_count;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b0)) u_std (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_clr_err(clr),
    .i_wr_en(wr), .i_wr_data(wdata), .o_full(s_full), .o_almost_full(s_af),
    .i_rd_en(rd), .o_rd_data(s_data), .o_rd_valid(s_valid), .o_rd_empty(s_empty),
    .o_almost_empty(s_ae), .o_count(s_count), .o_overflow(s_ovf), .o_underflow(s_unf));

  sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b1)) u_fw (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_clr_err(clr),
    .i_wr_en(wr), .i_wr_data(wdata), .o_full(f_full), .o_almost_full(f_af),
    .i_rd_en(rd), .o_rd_data(f_data), .o_rd_valid(f_valid), .o_rd_empty(f_empty),
    .o_almost_empty(f_ae), .o_count(f_count), .o_overflow(f_ovf), .o_underflow(f_unf));

  int checks = 0, errors = 0;

  // reference model
  logic [DW-1:0] q[$];
  logic m_ovf, m_unf, m_valid;
  logic [DW-1:0] m_data;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_unf = 0; m_valid = 0; m_data = '0;
  endtask

  task automatic model_step(bit fl, bit cl, bit w, logic [DW-1:0] d, bit r);
    bit set_o, set_u, rd_ok, wr_ok;
    set_o = 0; set_u = 0;
    if (fl) begin
      q.delete();
      m_valid = 0;
    end else begin
      rd_ok = r && q.size() > 0;
      wr_ok = w && (q.size() < DEPTH || rd_ok);
      set_o = w && !wr_ok;
      set_u = r && q.size() == 0;
      m_valid = rd_ok;
      if (rd_ok) m_data = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
    m_ovf = set_o ? 1'b1 : (cl ? 1'b0 : m_ovf);
    m_unf = set_u ? 1'b1 : (cl ? 1'b0 : m_unf);
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("s_count", 32'(s_count), n);        chk("f_count", 32'(f_count), n);
    chk("s_full", s_full, n == DEPTH);      chk("f_full", f_full, n == DEPTH);
    chk("s_af", s_af, n >= AF);             chk("f_af", f_af, n >= AF);
    chk("s_empty", s_empty, n == 0);        chk("f_empty", f_empty, n == 0);
    chk("s_ae", s_ae, n <= AE);             chk("f_ae", f_ae, n <= AE);
    chk("s_ovf", s_ovf, m_ovf);             chk("f_ovf", f_ovf, m_ovf);
    chk("s_unf", s_unf, m_unf);             chk("f_unf", f_unf, m_unf);
    chk("s_valid", s_valid, m_valid);       chk("s_data", 32'(s_data), 32'(m_data));
    chk("f_valid", f_valid, n != 0);
    if (n != 0) chk("f_data", 32'(f_data), 32'(q[0]));
  endtask

  task automatic step(bit fl, bit cl, bit w, logic [DW-1:0] d, bit r);
    flush = fl; clr = cl; wr = w; wdata = d; rd = r;
    @(posedge clk);
    model_step(fl, cl, w, d, r);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    flush = 0; clr = 0; wr = 0; rd = 0; wdata = '0;
    rst = 1;
    model_reset();
    @(posedge clk); @(posedge clk);
    #1 rst = 0;
    check_all();
  endtask

  typedef struct {
    bit fl, cl, w, r;
    logic [DW-1:0] d;
    int cnt;
    bit emp, unf;
  } vec_t;
  vec_t vt[9];

  initial begin
    rst = 1; flush = 0; clr = 0; wr = 0; rd = 0; wdata = '0;
    model_reset();
    #2;
    chk("rst_s_data", 32'(s_data), 0);  chk("rst_s_valid", s_valid, 0);
    chk("rst_f_empty", f_empty, 1);     chk("rst_s_ae", s_ae, 1);
    do_reset();

    // vector table: underflow, simultaneous rd/wr on empty, clear vs set
    vt[0] = '{0,0,1,0,12'h111,1,0,0};
    vt[1] = '{0,0,1,1,12'h222,1,0,0};
    vt[2] = '{0,0,0,1,12'h000,0,1,0};
    vt[3] = '{0,0,0,1,12'h000,0,1,1};
    vt[4] = '{0,1,0,0,12'h000,0,1,0};
    vt[5] = '{0,0,1,1,12'h333,1,0,1};
    vt[6] = '{0,1,0,1,12'h000,0,1,0};
    vt[7] = '{0,1,0,1,12'h000,0,1,1};
    vt[8] = '{0,1,0,0,12'h000,0,1,0};
    for (int i = 0; i < 9; i++) begin
      step(vt[i].fl, vt[i].cl, vt[i].w, vt[i].d, vt[i].r);
      chk($sformatf("vec%0d_count", i), 32'(s_count), vt[i].cnt);
      chk($sformatf("vec%0d_empty", i), f_empty, vt[i].emp);
      chk($sformatf("vec%0d_unf", i), s_unf, vt[i].unf);
    end
    chk("vec6_data", 32'(s_data), 32'h333);

    // fill to full, overflow, drain in order
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 1, DW'(i), 0);
      chk("t1_af", s_af, i >= 14);
    end
    chk("t1_full", s_full, 1);
    step(0, 0, 1, 12'h011, 0);
    chk("t1_ovf", s_ovf, 1);  chk("t1_cnt", 32'(s_count), 16);
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 0, '0, 1);
      chk("t1_rdata", 32'(s_data), i);  chk("t1_rvalid", s_valid, 1);
    end
    step(0, 0, 0, '0, 0);
    chk("t1_rvalid_idle", s_valid, 0);

    // FWFT fall-through
    do_reset();
    step(0, 0, 1, 12'hABC, 0);
    chk("t2_empty", f_empty, 0);  chk("t2_data", 32'(f_data), 32'hABC);
    step(0, 0, 0, '0, 1);
    chk("t2_empty_pop", f_empty, 1);  chk("t2_cnt", 32'(f_count), 0);

    // full with concurrent rd/wr across pointer wrap
    do_reset();
    for (int i = 0; i < 16; i++) step(0, 0, 1, DW'(12'h100 + i), 0);
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 1, DW'(12'h200 + i), 1);
      chk("t3_cnt", 32'(s_count), 16);  chk("t3_ovf", f_ovf, 0);
      chk("t3_data", 32'(s_data), i < 16 ? 32'h100 + i : 32'h200 + i - 16);
    end

    // flush with concurrent rd/wr at count 9
    do_reset();
    for (int i = 0; i < 9; i++) step(0, 0, 1, DW'(12'h300 + i), 0);
    step(1, 0, 1, 12'h3FF, 1);
    chk("t5_cnt", 32'(f_count), 0);  chk("t5_empty", s_empty, 1);
    chk("t5_ae", f_ae, 1);           chk("t5_ovf", s_ovf, 0);
    chk("t5_unf", f_unf, 0);         chk("t5_valid", s_valid, 0);

    // asynchronous reset mid-burst
    for (int i = 0; i < 3; i++) step(0, 0, 1, DW'(12'h5A0 + i), i == 2);
    #3 rst = 1;
    #1;
    chk("t6_cnt", 32'(s_count), 0);  chk("t6_empty", f_empty, 1);
    chk("t6_data", 32'(s_data), 0);  chk("t6_valid", s_valid, 0);
    chk("t6_fvalid", f_valid, 0);    chk("t6_ae", s_ae, 1);
    wr = 0; rd = 0;
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    step(0, 0, 1, 12'h7E1, 0);
    chk("t6_fdata", 32'(f_data), 32'h7E1);
    step(0, 0, 0, '0, 1);
    chk("t6_sdata", 32'(s_data), 32'h7E1);

    // randomized traffic in phases biased toward full and toward empty
    do_reset();
    for (int i = 0; i < 800; i++) begin
      int wp;
      wp = ((i / 100) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 99) < wp, DW'($urandom), $urandom_range(0, 99) >= wp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Parametrised single-clock FIFO for same-domain pixel buffering, e.g. between the capture formatter and the filter pipeline once data is in the system clock domain. It is the successor to the dual-clock FIFO. It adds the following:
- selectable standard or first-word-fall-through (FWFT) read mode
- exact occupancy count
- programmable almost-full and almost-empty flags
- sticky overflow and underflow error flags
- synchronous flush

Parameters:
DATA_WIDTH, 12, width of the data word
ADDR_WIDTH, 4, depth DEPTH = 2^ADDR_WIDTH words; capacity is exactly DEPTH in both modes
FWFT, 0, read mode: 0 = standard (registered read, 1-cycle latency), 1 = first-word-fall-through
AF_THRESH, DEPTH-2, o_almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 2, o_almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1

Ports:
i_clk  input  1  clock; all logic rises on posedge
i_rst  input  1  reset, asynchronous, active-high
i_flush  input  1  synchronous flush; empties the FIFO
i_clr_err  input  1  synchronous clear of the sticky error flags
i_wr_en  input  1  write request
i_wr_data  input  DATA_WIDTH  write data
o_full  output  1  count == DEPTH
o_almost_full  output  1  count >= AF_THRESH
i_rd_en  input  1  read request (FWFT: pop the head word)
o_rd_data  output  DATA_WIDTH  read data (FWFT: current head word)
o_rd_valid  output  1  standard mode: o_rd_data updated this cycle; FWFT: equals !o_rd_empty
o_rd_empty  output  1  count == 0
o_almost_empty  output  1  count <= AE_THRESH
o_count  output  ADDR_WIDTH+1  words held, 0..DEPTH
o_overflow  output  1  sticky: a write was attempted while full and not accepted
o_underflow  output  1  sticky: a read was attempted while empty

Behaviour:
Reset (i_rst high, asynchronous):
- Pointers and count are 0.
- o_rd_data=0, o_rd_valid=0, o_rd_empty=1, o_full=0, o_count=0, o_almost_empty=1.
- o_almost_full=0, o_overflow=0, o_underflow=0.
- Memory contents are not reset.

Status outputs:
- All status outputs are registered, or derived solely from the registered count.
- They update on the same edge as the count.

Acceptance rules:
- Write is accepted when i_wr_en && (!o_full || read accepted in the same cycle).
- Read is accepted when i_rd_en && !o_rd_empty.

Simultaneous read and write:
- When full: both are accepted, count unchanged, no overflow.
- When empty: the write is accepted; the read is rejected, o_underflow sets, count +1.
- Otherwise, with both accepted, count is unchanged.

Count:
- next count = count + wr_acc - rd_acc.
- Pointers are ADDR_WIDTH bits and wrap modulo DEPTH.

Standard mode (FWFT=0):
- An accepted read at edge N loads the head word into o_rd_data at edge N.
- o_rd_valid is high for exactly the cycle after N.
- o_rd_data holds its value when no read is accepted.

FWFT mode (FWFT=1):
- o_rd_data shows the head word whenever o_rd_empty=0.
- A write into an empty FIFO at edge N gives o_rd_empty=0 and valid o_rd_data after edge N (bypass into the output stage, 1-cycle latency).
- An accepted read at edge N presents the next word after edge N, or raises o_rd_empty if none remains.
- o_count includes the output stage.

Errors:
- o_overflow sets on i_wr_en while full with no concurrent accepted read.
- o_underflow sets on i_rd_en while empty.
- Both flags stay set until i_clr_err or reset.
- If an error event coincides with i_clr_err, set wins.

Flush:
- Priority: i_rst > i_flush > read/write.
- Flush sets pointers and count to 0, o_rd_empty=1, o_rd_valid=0.
- Any read or write in the same cycle is ignored, and flagged as neither error.
- Flush does not clear the error flags or o_rd_data.

Test Plan:
1. Standard mode, DEPTH 16: write 0x001..0x010 back-to-back → o_full=1 after the 16th edge, o_almost_full=1 from count 14; 17th write → o_overflow=1, count stays 16, then drain → reads return 0x001..0x010 in order, each o_rd_valid one cycle after i_rd_en.
2. FWFT mode: single write 0xABC into empty FIFO → next cycle o_rd_empty=0 and o_rd_data=0xABC with no read; pop → o_rd_empty=1, o_count=0.
3. Full with simultaneous rd+wr for 40 cycles → o_count stays 16, o_overflow=0, data order preserved across pointer wrap (≥2 full wraps).
4. Empty with simultaneous rd+wr → o_underflow=1, o_count=1, word retained; i_clr_err pulse → o_underflow=0.
5. Count 9 with i_flush+i_wr_en+i_rd_en in the same cycle → o_count=0, o_rd_empty=1, o_almost_empty=1, no error flags set.
6. i_rst asserted mid-burst between clock edges → outputs reach reset values immediately; after release, first write/read pair returns the new data, not stale data.
